// File: rtl/uart_pkg.sv
// uart_pkg - shared types and helpers for the serial receive path.
//   rx_state_t  : receiver FSM state encoding
//   PAR_*       : parity mode codes (none / even / odd)
//   parity_calc : expected parity bit for a payload under a given mode
//   maj3        : 2-of-3 majority vote used by the majority sampling option
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Expected parity bit for up to 9 payload bits; narrower payloads are
    // zero-extended by the caller, which does not change the XOR.
    function automatic logic parity_calc(input logic [8:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~(^data);
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if - line-side and host-side signals of the UART receiver.
//   s_tick       : oversample enable from the shared baud generator
//   rx           : asynchronous serial line, idle high
//   dout         : received payload, held until the next completed frame
//   rx_done_tick : one-clk pulse per completed frame (errors included)
//   parity_err   : parity mismatch of the last completed frame
//   frame_err    : stop-bit error of the last completed frame
//   busy         : receiver is not idle
// Modports: master drives the line and tick, slave is the receiver.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 s_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_done_tick;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output s_tick,
        output rx,
        input  dout,
        input  rx_done_tick,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  s_tick,
        input  rx,
        output dout,
        output rx_done_tick,
        output parity_err,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2 - two-flop synchroniser for an asynchronous serial input.
//   clk   : destination clock
//   reset : asynchronous active-high reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles of latency
// RESET_VAL defaults to 1 so an idle-high line does not look like a falling
// edge straight out of reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg - parametrised UART receiver driven by an oversampling tick.
//   clk   : system clock, all logic on the rising edge
//   reset : asynchronous active-high reset
//   bus   : uart_rx_cfg_if.slave (s_tick, rx in; dout, rx_done_tick,
//           parity_err, frame_err, busy out; all outputs registered)
// Parameters: DATA_BITS (5..9), OVERSAMPLE (8..32, even),
//             PARITY_MODE (0 none, 1 even, 2 odd), STOP_BITS (1..2).
// Build option UART_RX_MAJORITY_EN: every mid-bit decision becomes a 2-of-3
// vote over three consecutive ticks and is taken one tick later than the
// single-sample point.
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    uart_rx_cfg_if.slave     bus
);

    import uart_pkg::*;

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_EN
    // Decision moves one tick later so the vote window is centred on the
    // single-sample point. Because the counter is re-zeroed one tick late in
    // START, the later states keep deciding at OVERSAMPLE-1 and their window
    // still lands symmetrically around the bit centre.
    localparam int START_MID = OVERSAMPLE / 2;
`else
    localparam int START_MID = OVERSAMPLE / 2 - 1;
`endif

    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(START_MID);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [1:0]        PAR_MODE  = 2'(PARITY_MODE);

    logic rx_s;
    logic bit_s;

    rx_state_t            state_r,     state_n;
    logic [TICK_W-1:0]    cnt_r,       cnt_n;
    logic [BIT_W-1:0]     bit_cnt_r,   bit_cnt_n;
    logic [DATA_BITS-1:0] sh_r,        sh_n;
    logic                 armed_r,     armed_n;
    logic                 perr_acc_r,  perr_acc_n;
    logic                 ferr_acc_r,  ferr_acc_n;
    logic [DATA_BITS-1:0] dout_r,      dout_n;
    logic                 done_r,      done_n;
    logic                 perr_r,      perr_n;
    logic                 ferr_r,      ferr_n;
    logic                 busy_r,      busy_n;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // History of the two previous tick samples for the majority vote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= 2'b11;
        end else if (bus.s_tick) begin
            hist_r <= {hist_r[0], rx_s};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign bit_s = maj3(hist_r[1], hist_r[0], rx_s);
`else
    assign bit_s = rx_s;
`endif

    // Next-state, counters, datapath and output-register next values.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        bit_cnt_n  = bit_cnt_r;
        sh_n       = sh_r;
        armed_n    = armed_r;
        perr_acc_n = perr_acc_r;
        ferr_acc_n = ferr_acc_r;
        dout_n     = dout_r;
        done_n     = 1'b0;
        perr_n     = perr_r;
        ferr_n     = ferr_r;

        if (bus.s_tick) begin
            case (state_r)
                IDLE: begin
                    // Arming requires the line to be seen high on a tick, so
                    // a line that stays low after a break never retriggers.
                    armed_n = rx_s;
                    if (!rx_s && armed_r) begin
                        state_n = START;
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end

                START: begin
                    if (cnt_r == MID_TICK) begin
                        cnt_n = '0;
                        if (!bit_s) begin
                            state_n    = DATA;
                            bit_cnt_n  = '0;
                            perr_acc_n = 1'b0;
                            ferr_acc_n = 1'b0;
                        end else begin
                            // Start bit did not hold to mid-bit: a glitch.
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt_r + TICK_W'(1);
                    end
                end

                DATA: begin
                    if (cnt_r == LAST_TICK) begin
                        cnt_n = '0;
                        // LSB arrives first, so shift right from the top.
                        sh_n  = {bit_s, sh_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_n = '0;
                            if (PAR_MODE != PAR_NONE) begin
                                state_n = PARITY;
                            end else begin
                                state_n = STOP;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_r + TICK_W'(1);
                    end
                end

                PARITY: begin
                    if (cnt_r == LAST_TICK) begin
                        cnt_n      = '0;
                        perr_acc_n = parity_calc(9'(sh_r), PAR_MODE) ^ bit_s;
                        state_n    = STOP;
                    end else begin
                        cnt_n = cnt_r + TICK_W'(1);
                    end
                end

                STOP: begin
                    if (cnt_r == LAST_TICK) begin
                        cnt_n = '0;
                        if (bit_cnt_r == STOP_LAST) begin
                            // Last stop sample: publish the frame.
                            dout_n    = sh_r;
                            done_n    = 1'b1;
                            perr_n    = perr_acc_r;
                            ferr_n    = ferr_acc_r | ~bit_s;
                            bit_cnt_n = '0;
                            armed_n   = 1'b0;
                            state_n   = IDLE;
                        end else begin
                            ferr_acc_n = ferr_acc_r | ~bit_s;
                            bit_cnt_n  = bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_r + TICK_W'(1);
                    end
                end

                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end else begin
            state_n = state_r;
        end

        // busy is registered from the next state so it tracks state_r exactly.
        busy_n = (state_n != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= '0;
            sh_r       <= '0;
            armed_r    <= 1'b0;
            perr_acc_r <= 1'b0;
            ferr_acc_r <= 1'b0;
            dout_r     <= '0;
            done_r     <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            bit_cnt_r  <= bit_cnt_n;
            sh_r       <= sh_n;
            armed_r    <= armed_n;
            perr_acc_r <= perr_acc_n;
            ferr_acc_r <= ferr_acc_n;
            dout_r     <= dout_n;
            done_r     <= done_n;
            perr_r     <= perr_n;
            ferr_r     <= ferr_n;
            busy_r     <= busy_n;
        end
    end

    assign bus.dout         = dout_r;
    assign bus.rx_done_tick = done_r;
    assign bus.parity_err   = perr_r;
    assign bus.frame_err    = ferr_r;
    assign bus.busy         = busy_r;

endmodule
